// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl -- instruction-fetch stage sequencer
//
// Purpose:
//   Converts L1i miss/refill status, back-end back-pressure and branch/trap
//   redirect requests into the stall and flush controls used by the IF stage.
//   It generates the stall-episode start pulse and applies redirect priority
//   (a trap beats a branch). Redirects that arrive while a miss is outstanding
//   are held until the refill completes.
//
// Build option:
//   FETCH_PERF_CTR_EN - when defined, adds two saturating performance counters
//                       (miss stall cycles, issued redirects). When undefined,
//                       the counter outputs are tied to zero and no counter
//                       flops exist.
//
// Ports:
//   clk_i                 core clock
//   rst_ni                asynchronous active-low reset
//   clk_en_i              global clock enable; when 0 all state and outputs hold
//   l1i_miss_i            L1i miss for the current fetch address
//   l1i_refill_done_i     L1i refill complete (single-cycle pulse)
//   backend_stall_i       decode/back-end cannot accept an instruction
//   br_redirect_en_i      branch mispredict redirect request
//   br_redirect_addr_i    branch target
//   trap_redirect_en_i    trap/exception redirect request
//   trap_redirect_addr_i  trap vector
//   stall_o               {stallEn, start} to IF
//   flush_o               {flushEn, flushAddress[width-1:0]} to IF
//   miss_stall_cycles_o   perf counter: cycles spent waiting for a refill
//   redirect_count_o      perf counter: flush cycles issued
// -----------------------------------------------------------------------------
module fetch_ctrl #(
   parameter int width = 32,
   parameter int CTR_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clk_en_i,
   input  logic             l1i_miss_i,
   input  logic             l1i_refill_done_i,
   input  logic             backend_stall_i,
   input  logic             br_redirect_en_i,
   input  logic [width-1:0] br_redirect_addr_i,
   input  logic             trap_redirect_en_i,
   input  logic [width-1:0] trap_redirect_addr_i,
   output logic [1:0]       stall_o,
   output logic [width:0]   flush_o,
   output logic [CTR_W-1:0] miss_stall_cycles_o,
   output logic [CTR_W-1:0] redirect_count_o
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      MISS  = 2'd1,
      REDIR = 2'd2
   } state_e;

   // Redirect targets are word aligned: bits [1:0] are always cleared.
   localparam logic [width-1:0] ALIGN_MASK = {{(width-2){1'b1}}, 2'b00};

   state_e             state_q, state_d;
   logic               stall_en_q, stall_en_d;
   logic               start_q, start_d;
   logic               flush_en_q, flush_en_d;
   logic [width-1:0]   flush_addr_q, flush_addr_d;

   // Redirect held while a miss is outstanding.
   logic               pend_valid_q, pend_valid_d;
   logic               pend_trap_q, pend_trap_d;
   logic [width-1:0]   pend_addr_q, pend_addr_d;

   logic               redir_req;
   logic [width-1:0]   br_addr_aligned;
   logic [width-1:0]   trap_addr_aligned;
   logic [width-1:0]   redir_sel;

   // Pending register after folding in this cycle's redirect requests.
   logic               merge_valid;
   logic               merge_trap;
   logic [width-1:0]   merge_addr;

   assign br_addr_aligned   = br_redirect_addr_i & ALIGN_MASK;
   assign trap_addr_aligned = trap_redirect_addr_i & ALIGN_MASK;
   assign redir_req         = br_redirect_en_i | trap_redirect_en_i;
   assign redir_sel         = trap_redirect_en_i ? trap_addr_aligned : br_addr_aligned;

   // A trap always replaces the held redirect; a branch may only replace a
   // held branch, so a pending trap can never be lost to a later branch.
   always_comb begin
      merge_valid = pend_valid_q;
      merge_trap  = pend_trap_q;
      merge_addr  = pend_addr_q;
      if (trap_redirect_en_i) begin
         merge_valid = 1'b1;
         merge_trap  = 1'b1;
         merge_addr  = trap_addr_aligned;
      end else if (br_redirect_en_i && !(pend_valid_q && pend_trap_q)) begin
         merge_valid = 1'b1;
         merge_trap  = 1'b0;
         merge_addr  = br_addr_aligned;
      end
   end

   // Next-state and next-output logic. All outputs are registered, so the
   // values computed here appear on the ports in the following cycle.
   always_comb begin
      state_d      = state_q;
      stall_en_d   = 1'b0;
      start_d      = 1'b0;
      flush_en_d   = 1'b0;
      flush_addr_d = flush_addr_q;
      pend_valid_d = pend_valid_q;
      pend_trap_d  = pend_trap_q;
      pend_addr_d  = pend_addr_q;

      unique case (state_q)
         RUN, REDIR: begin
            // Nothing can be pending outside MISS.
            pend_valid_d = 1'b0;
            pend_trap_d  = 1'b0;
            if (redir_req) begin
               // stallEn accompanies flushEn so IF loads the new address.
               state_d      = REDIR;
               flush_en_d   = 1'b1;
               flush_addr_d = redir_sel;
               stall_en_d   = 1'b1;
            end else if ((state_q == RUN) && l1i_miss_i) begin
               // A miss seen during REDIR belongs to the squashed address.
               // The start pulse is suppressed only if start was already
               // high this cycle, so start never lasts two cycles.
               state_d    = MISS;
               stall_en_d = 1'b1;
               start_d    = !start_q;
            end else if (backend_stall_i) begin
               state_d    = RUN;
               stall_en_d = 1'b1;
               start_d    = !stall_en_q;
            end else begin
               state_d    = RUN;
            end
         end

         MISS: begin
            if (l1i_refill_done_i) begin
               // Any redirect arriving with the refill was folded into
               // merge_* first, so it is honoured here.
               pend_valid_d = 1'b0;
               pend_trap_d  = 1'b0;
               if (merge_valid) begin
                  state_d      = REDIR;
                  flush_en_d   = 1'b1;
                  flush_addr_d = merge_addr;
                  stall_en_d   = 1'b1;
               end else begin
                  state_d    = RUN;
                  stall_en_d = backend_stall_i;
               end
            end else begin
               pend_valid_d = merge_valid;
               pend_trap_d  = merge_trap;
               pend_addr_d  = merge_addr;
               stall_en_d   = 1'b1;
            end
         end

         default: begin
            state_d      = RUN;
            pend_valid_d = 1'b0;
            pend_trap_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= RUN;
         stall_en_q   <= 1'b0;
         start_q      <= 1'b0;
         flush_en_q   <= 1'b0;
         flush_addr_q <= '0;
         pend_valid_q <= 1'b0;
         pend_trap_q  <= 1'b0;
         pend_addr_q  <= '0;
      end else if (clk_en_i) begin
         state_q      <= state_d;
         stall_en_q   <= stall_en_d;
         start_q      <= start_d;
         flush_en_q   <= flush_en_d;
         flush_addr_q <= flush_addr_d;
         pend_valid_q <= pend_valid_d;
         pend_trap_q  <= pend_trap_d;
         pend_addr_q  <= pend_addr_d;
      end
   end

   assign stall_o = {stall_en_q, start_q};
   assign flush_o = {flush_en_q, flush_addr_q};

`ifdef FETCH_PERF_CTR_EN
   localparam logic [CTR_W-1:0] CTR_ONE = {{(CTR_W-1){1'b0}}, 1'b1};
   localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

   logic [CTR_W-1:0] miss_cnt_q;
   logic [CTR_W-1:0] redir_cnt_q;

   // Each counter samples the cycle that is just ending: a MISS cycle or a
   // cycle in which flushEn was presented to IF. Both stick at all-ones.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         miss_cnt_q  <= '0;
         redir_cnt_q <= '0;
      end else if (clk_en_i) begin
         if ((state_q == MISS) && (miss_cnt_q != CTR_MAX)) begin
            miss_cnt_q <= miss_cnt_q + CTR_ONE;
         end
         if (flush_en_q && (redir_cnt_q != CTR_MAX)) begin
            redir_cnt_q <= redir_cnt_q + CTR_ONE;
         end
      end
   end

   assign miss_stall_cycles_o = miss_cnt_q;
   assign redirect_count_o    = redir_cnt_q;
`else
   assign miss_stall_cycles_o = '0;
   assign redirect_count_o    = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl -- self-checking bench for fetch_ctrl
//
// Directed scenarios followed by randomized traffic. Every cycle the DUT
// outputs are compared with a behavioural model of the fetch sequencer kept
// in this file. Counters use a narrow width so saturation is reachable when
// FETCH_PERF_CTR_EN is defined.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

   localparam int W    = 32;
   localparam int CW   = 6;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clk_en;
   logic          l1i_miss;
   logic          refill;
   logic          bstall;
   logic          br_en;
   logic [W-1:0]  br_addr;
   logic          trap_en;
   logic [W-1:0]  trap_addr;
   logic [1:0]    stall;
   logic [W:0]    flush;
   logic [CW-1:0] miss_ctr;
   logic [CW-1:0] redir_ctr;

   fetch_ctrl #(.width(W), .CTR_W(CW)) dut (
      .clk_i                (clk),
      .rst_ni               (rst_n),
      .clk_en_i             (clk_en),
      .l1i_miss_i           (l1i_miss),
      .l1i_refill_done_i    (refill),
      .backend_stall_i      (bstall),
      .br_redirect_en_i     (br_en),
      .br_redirect_addr_i   (br_addr),
      .trap_redirect_en_i   (trap_en),
      .trap_redirect_addr_i (trap_addr),
      .stall_o              (stall),
      .flush_o              (flush),
      .miss_stall_cycles_o  (miss_ctr),
      .redirect_count_o     (redir_ctr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: "waiting for refill" flag, the held redirect, and the
   // values IF should currently see.
   bit         m_waiting;
   bit         m_pend_v;
   bit         m_pend_trap;
   logic [W-1:0] m_pend_a;
   bit         e_stall;
   bit         e_start;
   bit         e_flush;
   logic [W-1:0] e_addr;
   int         m_miss_cnt;
   int         m_redir_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_miss_ctr();
`ifdef FETCH_PERF_CTR_EN
      return m_miss_cnt;
`else
      return 0;
`endif
   endfunction

   function automatic int exp_redir_ctr();
`ifdef FETCH_PERF_CTR_EN
      return m_redir_cnt;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_waiting   = 1'b0;
      m_pend_v    = 1'b0;
      m_pend_trap = 1'b0;
      m_pend_a    = '0;
      e_stall     = 1'b0;
      e_start     = 1'b0;
      e_flush     = 1'b0;
      e_addr      = '0;
      m_miss_cnt  = 0;
      m_redir_cnt = 0;
   endtask

   // Applies the sequencing rules to the inputs sampled at a clock edge.
   task automatic model_edge();
      bit was_stall, was_start, was_flush;
      logic [W-1:0] br_a, tr_a;
      if (!rst_n || !clk_en) return;
      was_stall = e_stall;
      was_start = e_start;
      was_flush = e_flush;
      br_a = {br_addr[W-1:2], 2'b00};
      tr_a = {trap_addr[W-1:2], 2'b00};
      if (m_waiting && m_miss_cnt < CMAX) m_miss_cnt++;
      if (was_flush && m_redir_cnt < CMAX) m_redir_cnt++;
      e_flush = 1'b0;
      e_start = 1'b0;
      if (m_waiting) begin
         if (trap_en) begin
            m_pend_v = 1'b1; m_pend_trap = 1'b1; m_pend_a = tr_a;
         end else if (br_en && !(m_pend_v && m_pend_trap)) begin
            m_pend_v = 1'b1; m_pend_trap = 1'b0; m_pend_a = br_a;
         end
         if (refill) begin
            m_waiting = 1'b0;
            if (m_pend_v) begin
               e_flush = 1'b1; e_addr = m_pend_a; e_stall = 1'b1;
            end else begin
               e_stall = bstall;
            end
            m_pend_v = 1'b0;
            m_pend_trap = 1'b0;
         end else begin
            e_stall = 1'b1;
         end
      end else if (trap_en || br_en) begin
         e_flush = 1'b1;
         e_addr  = trap_en ? tr_a : br_a;
         e_stall = 1'b1;
      end else if (l1i_miss && !was_flush) begin
         m_waiting = 1'b1;
         e_stall   = 1'b1;
         e_start   = !was_start;
      end else if (bstall) begin
         e_stall = 1'b1;
         e_start = !was_stall;
      end else begin
         e_stall = 1'b0;
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".stallEn"}, 64'(stall[1]), 64'(e_stall));
      check({tag, ".start"},   64'(stall[0]), 64'(e_start));
      check({tag, ".flushEn"}, 64'(flush[W]), 64'(e_flush));
      if (e_flush) check({tag, ".flushAddr"}, 64'(flush[W-1:0]), 64'(e_addr));
      check({tag, ".missCtr"},  64'(miss_ctr),  64'(exp_miss_ctr()));
      check({tag, ".redirCtr"}, 64'(redir_ctr), 64'(exp_redir_ctr()));
   endtask

   // One clock: inputs already set, model follows the edge, outputs checked
   // on the falling edge.
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic clear_inputs();
      clk_en = 1'b1; l1i_miss = 1'b0; refill = 1'b0; bstall = 1'b0;
      br_en = 1'b0; br_addr = '0; trap_en = 1'b0; trap_addr = '0;
   endtask

   // Asserts reset between clock edges and checks outputs clear at once.
   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_outputs(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      clear_inputs();
      model_reset();

      // Reset and idle.
      #2 rst_n = 1'b0;
      #1 check_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step("idle");

      // Miss, refill after seven stalled cycles.
      l1i_miss = 1'b1;
      step("miss_start");
      check("miss_start.start_pulse", 64'(stall), 64'h3);
      l1i_miss = 1'b0;
      for (int i = 0; i < 6; i++) step("miss_wait");
      refill = 1'b1;
      step("miss_refill");
      refill = 1'b0;
      check("miss_end.stallEn", 64'(stall[1]), 64'h0);
`ifdef FETCH_PERF_CTR_EN
      check("miss_end.missCtr", 64'(miss_ctr), 64'd7);
`endif
      step("miss_after");

      // Branch redirect from RUN, low address bits dropped.
      br_en = 1'b1; br_addr = 32'h0000_1003;
      step("br_redir");
      check("br_redir.flush", 64'(flush), {31'h0, 1'b1, 32'h0000_1000});
      check("br_redir.stall", 64'(stall), 64'h2);
      br_en = 1'b0;
      step("br_redir_end");
      check("br_redir_end.flushEn", 64'(flush[W]), 64'h0);

      // Trap wins over a simultaneous branch.
      async_reset("reset_before_prio");
      br_en = 1'b1; br_addr = 32'h0000_2000;
      trap_en = 1'b1; trap_addr = 32'h0000_0080;
      step("prio");
      check("prio.flush", 64'(flush), {31'h0, 1'b1, 32'h0000_0080});
      br_en = 1'b0; trap_en = 1'b0;
      step("prio_end");
`ifdef FETCH_PERF_CTR_EN
      check("prio_end.redirCtr", 64'(redir_ctr), 64'd1);
`endif

      // Held redirects during a miss: later branch must not replace a trap.
      l1i_miss = 1'b1;
      step("hold_miss");
      l1i_miss = 1'b0;
      trap_en = 1'b1; trap_addr = 32'h0000_0100;
      step("hold_trap");
      trap_en = 1'b0;
      br_en = 1'b1; br_addr = 32'h0000_3000;
      step("hold_br");
      check("hold_br.noflush", 64'(flush[W]), 64'h0);
      br_en = 1'b0;
      step("hold_wait");
      refill = 1'b1;
      step("hold_refill");
      check("hold_refill.flush", 64'(flush), {31'h0, 1'b1, 32'h0000_0100});
      refill = 1'b0;
      step("hold_end");
      check("hold_end.flushEn", 64'(flush[W]), 64'h0);

      // Back-end stall with a clock-enable gap: outputs hold through the gap.
      for (int i = 0; i < 2; i++) step("bs_idle");
      bstall = 1'b1;
      step("bs_first");
      check("bs_first.stall", 64'(stall), 64'h3);
      clk_en = 1'b0;
      step("bs_gated");
      check("bs_gated.hold", 64'(stall), 64'h3);
      clk_en = 1'b1;
      step("bs_cont");
      step("bs_cont2");
      bstall = 1'b0;
      step("bs_end");
      check("bs_end.stallEn", 64'(stall[1]), 64'h0);

      // Asynchronous reset while waiting for a refill.
      l1i_miss = 1'b1;
      step("rst_miss");
      l1i_miss = 1'b0;
      step("rst_miss_wait");
      async_reset("rst_mid_miss");
      step("rst_after");
      check("rst_after.run", 64'(stall[1]), 64'h0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         clk_en    = ($urandom_range(0, 9) != 0);
         l1i_miss  = ($urandom_range(0, 7) == 0);
         refill    = ($urandom_range(0, 5) == 0);
         bstall    = ($urandom_range(0, 3) == 0);
         br_en     = ($urandom_range(0, 11) == 0);
         br_addr   = $urandom;
         trap_en   = ($urandom_range(0, 23) == 0);
         trap_addr = $urandom;
         if ($urandom_range(0, 599) == 0) async_reset("rand_reset");
         else step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencer for the instruction-fetch stage.
- Turns L1i miss/refill status, backend back-pressure, and branch/trap redirects into the stall_t and flush_req_t controls consumed by the IF stage.
- Owns the stall-episode start pulse, redirect priority, and holding of redirects that arrive during a miss.
- Sits between the L1i, the execute/commit redirect sources, and IF.

Parameters:
- width, 32, address width of PC and redirect addresses.
- CTR_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- clkEn  in  1  global clock enable; when 0, all state and outputs hold
- l1iMiss  in  1  L1i reports miss for the current fetch address
- l1iRefillDone  in  1  L1i refill complete, one-cycle pulse
- backendStall  in  1  decode/back-end cannot accept an instruction
- brRedirectEn  in  1  branch mispredict redirect request
- brRedirectAddr  in  width  branch target
- trapRedirectEn  in  1  trap/exception redirect request
- trapRedirectAddr  in  width  trap vector
- stall  out  stall_t  {stallEn, start} to IF
- flush  out  flush_req_t  {flushEn, flushAddress} to IF
- missStallCycles  out  CTR_W  perf counter
- redirectCount  out  CTR_W  perf counter

Behaviour:
- All outputs registered; inputs sampled on posedge clk only when clkEn=1.
- Reset (rst=0, any time, asynchronous):
  - state=RUN, pending redirect cleared.
  - stallEn=0, start=0, flushEn=0, flushAddress=0, counters=0.
- States:
  - RUN: normal fetch.
  - MISS: waiting for refill.
  - REDIR: one-cycle flush issue.
- Redirect select: if both redirect requests are sampled in the same cycle, the trap wins. Selected address has bits [1:0] forced to 0.
- RUN transitions, in priority order:
  - Redirect sampled at cycle N → REDIR. In N+1: flushEn=1, flushAddress=selected, stallEn=1, start=0. stallEn must accompany flushEn so IF loads the address.
  - Else l1iMiss sampled at N → MISS. In N+1: stallEn=1, start=1.
  - Else backendStall → stay in RUN. stallEn=1; start=1 only on the first stalled cycle after a non-stalled cycle.
  - Otherwise stallEn=0.
- MISS:
  - stallEn=1, start=0 after the first cycle.
  - Redirects are latched into the pending register:
    - A trap overwrites any pending redirect.
    - A branch overwrites only a pending branch, never a pending trap.
  - On l1iRefillDone: if a redirect is pending → REDIR, else → RUN with stallEn following backendStall.
  - If a redirect and l1iRefillDone arrive in the same cycle, the redirect is folded into pending first.
- REDIR:
  - Lasts exactly one cycle; flushEn deasserts the cycle after.
  - Pending register cleared.
  - Next state RUN.
  - A redirect sampled during REDIR starts a new REDIR next cycle. Back-to-back flushes are legal.
  - l1iMiss sampled during REDIR is ignored; it refers to the squashed address.
- start invariant: start=1 implies stallEn=1. start is never asserted in two consecutive cycles.
- clkEn=0: a pulse on l1iRefillDone or a redirect during that cycle is lost. Sources must hold requests until clkEn=1.

Optional Feature:
- FETCH_PERF_CTR_EN defined:
  - missStallCycles increments every clkEn cycle in MISS.
  - redirectCount increments on each flushEn cycle.
  - Both saturate at all-ones and reset to 0.
- Undefined: both outputs tied to 0, no counter flops.

Test Plan:
- Reset release, no requests, 10 cycles → stallEn=0, flushEn=0 throughout; assert rst=0 mid-MISS → outputs 0 immediately, state RUN.
- l1iMiss at cycle 5, l1iRefillDone at cycle 12:
  - stallEn=1 cycles 6–12, start=1 only in cycle 6, stallEn=0 at cycle 13.
  - With FETCH_PERF_CTR_EN, missStallCycles=7.
- brRedirectEn=1, brRedirectAddr=0x0000_1003 at cycle 4 in RUN → cycle 5: flushEn=1, stallEn=1, start=0, flushAddress=0x0000_1000; cycle 6: flushEn=0.
- Same-cycle brRedirectEn (0x2000) and trapRedirectEn (0x0080) → single flush to 0x0080; redirectCount=1.
- During MISS: trap 0x0100, then branch 0x3000, then refill done → single flush to 0x0100 in the cycle after refill.
- backendStall high cycles 3–6 with clkEn=0 at cycle 4:
  - stallEn=1 cycles 4–7; start=1 only at cycle 4.
  - Outputs hold during the clkEn=0 cycle.
